cordic_vectoring: RTL and testbench

//  Iterative CORDIC in vectoring mode: the inverse of the rotation datapath. Takes a Cartesian (x,y)

---
 rtl/cordic_vectoring.sv | 265 ++++++++++++++++++++++++++
 tb/tb_cordic_vectoring.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// ---------------------------------------------------------------------------
// cordic_vectoring
//
// Iterative vectoring-mode CORDIC. A Cartesian sample (x,y) is rotated onto
// the positive x axis one micro-rotation per clock. The accumulated rotation
// is returned as the phase and the final x as the magnitude. Only one vector
// is in flight at a time, with a valid/ready handshake on both sides.
//
// Optional feature macro: CORDIC_GAIN_COMP_EN
//   defined   : an extra SCALE cycle multiplies the magnitude by ~0.607299
//               (shift-add, truncated) to remove the CORDIC gain
//   undefined : magnitude is the raw CORDIC x (scaled by ~1.6468)
//
// Ports
//   clk_i    in   1          clock, rising edge
//   rst_i    in   1          synchronous reset, active-high
//   x_i      in   N_FRAC+1   signed input x, Q0.N_FRAC
//   y_i      in   N_FRAC+1   signed input y, Q0.N_FRAC
//   valid_i  in   1          x_i/y_i valid
//   ready_o  out  1          block idle, accepts input this cycle
//   mag_o    out  N_FRAC+3   signed magnitude (>= 0), Q2.N_FRAC
//   angle_o  out  N_FRAC+1   signed binary angle, +-1.0 full scale = +-pi
//   valid_o  out  1          mag_o/angle_o valid
//   ready_i  in   1          downstream accepts result
// ---------------------------------------------------------------------------
module cordic_vectoring #(
    parameter int N_FRAC         = 15,
    parameter int N_ITER         = 14,
    parameter int BW_SHIFT_VALUE = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [N_FRAC:0]   x_i,
    input  logic signed [N_FRAC:0]   y_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic signed [N_FRAC+2:0] mag_o,
    output logic signed [N_FRAC:0]   angle_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    localparam int W  = N_FRAC + 3;
    localparam int ZW = N_FRAC + 1;

    localparam logic [BW_SHIFT_VALUE-1:0] ITER_LAST = BW_SHIFT_VALUE'(N_ITER);
    localparam logic [BW_SHIFT_VALUE-1:0] ITER_ONE  = BW_SHIFT_VALUE'(1);

    localparam logic signed [ZW-1:0] Z_POS_QUARTER = {2'b01, {(ZW-2){1'b0}}};
    localparam logic signed [ZW-1:0] Z_NEG_QUARTER = {2'b11, {(ZW-2){1'b0}}};

    // The arctangent table is held at 2^15 scale; smaller N_FRAC builds
    // rescale it with round-half-up.
    localparam int          LUT_SHIFT = 15 - N_FRAC;
    localparam logic [31:0] LUT_HALF  = (LUT_SHIFT > 0) ? (32'd1 << (LUT_SHIFT - 1)) : 32'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROTATE,
`ifdef CORDIC_GAIN_COMP_EN
        S_SCALE,
`endif
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;
    logic signed [W-1:0]       r_x;
    logic signed [W-1:0]       r_y;
    logic signed [ZW-1:0]      r_z;
    logic [BW_SHIFT_VALUE-1:0] r_iterCount;
    logic                      r_zeroIn;
    logic signed [W-1:0]       r_mag;
    logic signed [ZW-1:0]      r_angle;

    logic signed [W-1:0]       w_xExt;
    logic signed [W-1:0]       w_yExt;
    logic signed [W-1:0]       w_xPre;
    logic signed [W-1:0]       w_yPre;
    logic signed [ZW-1:0]      w_zPre;
    logic signed [W-1:0]       w_xShift;
    logic signed [W-1:0]       w_yShift;
    logic signed [ZW-1:0]      w_atan;
    logic signed [W-1:0]       w_xNext;
    logic signed [W-1:0]       w_yNext;
    logic signed [ZW-1:0]      w_zNext;
    logic                      w_rotDone;
    logic signed [ZW-1:0]      w_angleFinal;
`ifdef CORDIC_GAIN_COMP_EN
    logic signed [W-1:0]       w_magScaled;
`endif

    // Arctangent of 2^-i as a fraction of pi, rounded to the angle LSB.
    function automatic logic signed [ZW-1:0] atanLut(input logic [BW_SHIFT_VALUE-1:0] idx);
        logic [31:0] v;
        case (int'(idx))
            0:       v = 32'd8192;
            1:       v = 32'd4836;
            2:       v = 32'd2555;
            3:       v = 32'd1297;
            4:       v = 32'd651;
            5:       v = 32'd326;
            6:       v = 32'd163;
            7:       v = 32'd81;
            8:       v = 32'd41;
            9:       v = 32'd20;
            10:      v = 32'd10;
            11:      v = 32'd5;
            12:      v = 32'd3;
            13:      v = 32'd1;
            14:      v = 32'd1;
            default: v = 32'd0;
        endcase
        v = (v + LUT_HALF) >> LUT_SHIFT;
        return v[ZW-1:0];
    endfunction

    assign w_xExt = {{2{x_i[N_FRAC]}}, x_i};
    assign w_yExt = {{2{y_i[N_FRAC]}}, y_i};

    // Fold the input into the right half-plane so the micro-rotations, which
    // cover only about +-100 degrees, can always converge. The widened
    // registers keep the negation of -1.0 representable.
    always_comb begin
        w_xPre = w_xExt;
        w_yPre = w_yExt;
        w_zPre = '0;
        if (x_i[N_FRAC]) begin
            if (!y_i[N_FRAC]) begin
                w_xPre = w_yExt;
                w_yPre = -w_xExt;
                w_zPre = Z_POS_QUARTER;
            end else begin
                w_xPre = -w_yExt;
                w_yPre = w_xExt;
                w_zPre = Z_NEG_QUARTER;
            end
        end
    end

    // One micro-rotation, steering y towards zero. All three updates are
    // computed from the pre-iteration register values.
    always_comb begin
        w_xShift = r_x >>> r_iterCount;
        w_yShift = r_y >>> r_iterCount;
        w_atan   = atanLut(r_iterCount);
        if (!r_y[W-1]) begin
            w_xNext = r_x + w_yShift;
            w_yNext = r_y - w_xShift;
            w_zNext = r_z + w_atan;
        end else begin
            w_xNext = r_x - w_yShift;
            w_yNext = r_y + w_xShift;
            w_zNext = r_z - w_atan;
        end
    end

    // The counter runs past the last iteration by one: that extra ROTATE
    // cycle only loads the output registers.
    assign w_rotDone    = (r_iterCount == ITER_LAST);
    assign w_angleFinal = r_zeroIn ? '0 : r_z;

`ifdef CORDIC_GAIN_COMP_EN
    // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13, each term truncated.
    assign w_magScaled = (r_x >>> 1) + (r_x >>> 3) - (r_x >>> 6) - (r_x >>> 9) - (r_x >>> 13);
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. DONE never accepts a new vector directly; the block
    // always passes through IDLE first.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    w_nextState = S_ROTATE;
                end
            end
            S_ROTATE: begin
                if (w_rotDone) begin
`ifdef CORDIC_GAIN_COMP_EN
                    w_nextState = S_SCALE;
`else
                    w_nextState = S_DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_SCALE: begin
                w_nextState = S_DONE;
            end
`endif
            S_DONE: begin
                if (ready_i) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath: capture with pre-rotation, iterate, then load the output
    // registers, which stay untouched until the next vector completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_iterCount <= '0;
            r_zeroIn    <= 1'b0;
            r_mag       <= '0;
            r_angle     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_x         <= w_xPre;
                        r_y         <= w_yPre;
                        r_z         <= w_zPre;
                        r_iterCount <= '0;
                        r_zeroIn    <= (x_i == '0) && (y_i == '0);
                    end
                end
                S_ROTATE: begin
                    if (!w_rotDone) begin
                        r_x         <= w_xNext;
                        r_y         <= w_yNext;
                        r_z         <= w_zNext;
                        r_iterCount <= r_iterCount + ITER_ONE;
                    end
`ifndef CORDIC_GAIN_COMP_EN
                    else begin
                        r_mag   <= r_x;
                        r_angle <= w_angleFinal;
                    end
`endif
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_SCALE: begin
                    r_mag   <= w_magScaled;
                    r_angle <= w_angleFinal;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign ready_o = (r_state == S_IDLE);
    assign valid_o = (r_state == S_DONE);
    assign mag_o   = r_mag;
    assign angle_o = r_angle;

endmodule

// File: tb/tb_cordic_vectoring.sv
// ---------------------------------------------------------------------------
// tb_cordic_vectoring
//
// Self-checking bench for cordic_vectoring. Expected phase and magnitude come
// from a floating-point atan2/sqrt model of each vector; expectations are
// queued when a vector is handed over and popped when valid_o appears.
// Honours CORDIC_GAIN_COMP_EN the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cordic_vectoring;

    localparam int  N_FRAC = 15;
    localparam int  N_ITER = 14;
    localparam real PI     = 3.14159265358979;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  LATENCY  = N_ITER + 2;
    localparam real MAG_GAIN = 1.6467602 * 0.607299;
`else
    localparam int  LATENCY  = N_ITER + 1;
    localparam real MAG_GAIN = 1.6467602;
`endif

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic signed [N_FRAC:0]   x_i;
    logic signed [N_FRAC:0]   y_i;
    logic                     valid_i;
    logic                     ready_o;
    logic signed [N_FRAC+2:0] mag_o;
    logic signed [N_FRAC:0]   angle_o;
    logic                     valid_o;
    logic                     ready_i;

    typedef struct {
        string tag;
        int    angle;
        int    angleTol;
        int    mag;
        int    magTol;
        int    startCycle;
    } exp_t;

    exp_t sbQ[$];
    exp_t lastExp;
    int   cycleCount  = 0;
    int   assertCount = 0;
    int   failCount   = 0;

    cordic_vectoring #(
        .N_FRAC(N_FRAC),
        .N_ITER(N_ITER),
        .BW_SHIFT_VALUE(4)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .x_i    (x_i),
        .y_i    (y_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .mag_o  (mag_o),
        .angle_o(angle_o),
        .valid_o(valid_o),
        .ready_i(ready_i)
    );

    // Free-running clock and an edge counter used for latency checks.
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cycleCount <= cycleCount + 1;
    end

    // Hard stop in case something wedges despite the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Compare observed against expected within +-tol; circular distance for
    // angles so that +pi and -pi are treated as neighbours.
    task automatic checkValue(input string tag, input int observed, input int expected,
                              input int tol, input bit circular);
        int d;
        d = observed - expected;
        if (circular) begin
            d = d & 32'h0000_FFFF;
            if (d > 32767) d = d - 65536;
        end
        if (d < 0) d = -d;
        assertCount++;
        assert ((d <= tol) === 1'b1)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    // Hand one vector to the DUT and queue its model result.
    task automatic applyStimulus(input string tag, input int x, input int y,
                                 input int angleTol, input int magTol);
        exp_t e;
        int   waitCycles;
        real  r;
        waitCycles = 0;
        while (ready_o !== 1'b1 && waitCycles < 50) begin
            @(posedge clk_i);
            #1;
            waitCycles++;
        end
        checkValue({tag, " ready_o before handshake"}, int'(ready_o), 1, 0, 1'b0);
        r          = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        e.tag      = tag;
        e.mag      = int'(r * MAG_GAIN);
        e.angle    = (x == 0 && y == 0) ? 0 : int'($atan2(real'(y), real'(x)) / PI * 32768.0);
        e.angleTol = angleTol;
        e.magTol   = magTol;
        x_i        = 16'(x);
        y_i        = 16'(y);
        valid_i    = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i      = 1'b0;
        e.startCycle = cycleCount;
        sbQ.push_back(e);
    endtask

    // Wait (bounded) for a result, pop the scoreboard and compare. With
    // releaseAfter the result is accepted and the return to IDLE checked.
    task automatic checkOutput(input bit releaseAfter);
        exp_t e;
        int   waitCycles;
        waitCycles = 0;
        while (valid_o !== 1'b1 && waitCycles < 100) begin
            @(posedge clk_i);
            #1;
            waitCycles++;
        end
        assertCount++;
        assert (valid_o === 1'b1)
        else begin
            failCount++;
            $error("[TB] FAIL result timeout: observed valid_o %b expected 1", valid_o);
        end
        assertCount++;
        assert (sbQ.size() > 0)
        else begin
            failCount++;
            $error("[TB] FAIL scoreboard: observed empty queue expected pending entry");
        end
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            lastExp = e;
            if (valid_o === 1'b1) begin
                checkValue({e.tag, " latency"}, cycleCount - e.startCycle, LATENCY, 0, 1'b0);
                checkValue({e.tag, " angle"}, int'(angle_o), e.angle, e.angleTol, 1'b1);
                checkValue({e.tag, " mag"}, int'(mag_o), e.mag, e.magTol, 1'b0);
            end
        end
        if (releaseAfter) begin
            ready_i = 1'b1;
            @(posedge clk_i);
            #1;
            ready_i = 1'b0;
            checkValue("release ready_o", int'(ready_o), 1, 0, 1'b0);
            checkValue("release valid_o", int'(valid_o), 0, 0, 1'b0);
        end
    endtask

    initial begin
        bit sawValid;

        $display("[TB] cordic_vectoring bench start");
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        x_i     = '0;
        y_i     = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state.
        checkValue("reset ready_o", int'(ready_o), 1, 0, 1'b0);
        checkValue("reset valid_o", int'(valid_o), 0, 0, 1'b0);
        checkValue("reset mag_o", int'(mag_o), 0, 0, 1'b0);
        checkValue("reset angle_o", int'(angle_o), 0, 0, 1'b1);

        // Axis and diagonal vectors.
        applyStimulus("x axis", 16384, 0, 2, 4);
        checkOutput(1'b1);
        applyStimulus("+y axis", 0, 16384, 2, 6);
        checkOutput(1'b1);
        applyStimulus("-y axis", 0, -16384, 2, 6);
        checkOutput(1'b1);
        applyStimulus("diagonal", 16384, 16384, 2, 6);
        checkOutput(1'b1);

        // Left half-plane near +-pi, and the -1.0 negation corner.
        applyStimulus("near +pi", -16384, 1, 4, 8);
        checkOutput(1'b1);
        applyStimulus("near -pi", -16384, -1, 4, 8);
        checkOutput(1'b1);
        applyStimulus("minus one", -32768, 0, 4, 10);
        checkOutput(1'b1);

        // General quadrants and the zero vector.
        applyStimulus("quadrant 4", 10000, -20000, 4, 10);
        checkOutput(1'b1);
        applyStimulus("zero", 0, 0, 0, 0);
        checkOutput(1'b1);

        // Downstream stall: outputs held, new input ignored while in DONE.
        applyStimulus("stall", 12000, -9000, 4, 10);
        checkOutput(1'b0);
        for (int i = 0; i < 5; i++) begin
            x_i     = 16'sd5;
            y_i     = 16'sd5;
            valid_i = 1'b1;
            @(posedge clk_i);
            #1;
            checkValue("stall valid_o", int'(valid_o), 1, 0, 1'b0);
            checkValue("stall ready_o", int'(ready_o), 0, 0, 1'b0);
            checkValue("stall angle", int'(angle_o), lastExp.angle, lastExp.angleTol, 1'b1);
            checkValue("stall mag", int'(mag_o), lastExp.mag, lastExp.magTol, 1'b0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        checkValue("stall release ready_o", int'(ready_o), 1, 0, 1'b0);
        checkValue("stall release valid_o", int'(valid_o), 0, 0, 1'b0);
        sawValid = 1'b0;
        for (int i = 0; i < N_ITER + 4; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o === 1'b1) sawValid = 1'b1;
        end
        checkValue("stall input ignored", int'(sawValid), 0, 0, 1'b0);

        // Back-to-back vectors, each accepted in the first IDLE cycle.
        applyStimulus("b2b first", 20000, 5000, 4, 10);
        checkOutput(1'b1);
        applyStimulus("b2b second", -25000, 12000, 4, 10);
        checkOutput(1'b1);

        // Reset during iteration 5 discards the vector in flight.
        x_i     = 16'sd20000;
        y_i     = 16'sd7000;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checkValue("mid reset ready_o", int'(ready_o), 1, 0, 1'b0);
        checkValue("mid reset valid_o", int'(valid_o), 0, 0, 1'b0);
        checkValue("mid reset mag_o", int'(mag_o), 0, 0, 1'b0);
        checkValue("mid reset angle_o", int'(angle_o), 0, 0, 1'b1);
        sawValid = 1'b0;
        for (int i = 0; i < N_ITER + 5; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o === 1'b1) sawValid = 1'b1;
        end
        checkValue("mid reset no output", int'(sawValid), 0, 0, 1'b0);

        // Block still works after the abort.
        applyStimulus("after reset", 9000, 30000, 4, 10);
        checkOutput(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
